// File: rtl/ntt_intt_pwm_clkgate_ctrl.sv
// Per-channel clock gating controller for the NTT/INTT/PWM datapath: idle-count
// auto-gating, request-driven wake with a stabilisation delay, and latch-based glitch-free gates.

module ntt_intt_pwm_clkgate_ch #(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_en_i,
  input  logic [CNT_W-1:0] cfg_idle_i,
  input  logic             busy_i,
  input  logic             req_i,
  output logic             ack_o,
  output logic             gated_o,
  output logic             clk_o
);
  localparam int WK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  typedef enum logic [1:0] {ST_ACTIVE, ST_GATED, ST_WAKE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [WK_W-1:0]   wake_q, wake_d;
  logic [CNT_W:0]    idle_inc;
  logic              idle;
  logic              en;
  logic              en_lat;

  assign idle     = ~busy_i & ~req_i;
  // One extra bit so the +1 compare cannot wrap when the counter is saturated.
  assign idle_inc = {1'b0, idle_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    case (state_q)
      ST_ACTIVE: begin
        if (!idle) begin
          idle_d = '0;
        end else if ((cfg_idle_i != '0) && (idle_inc >= {1'b0, cfg_idle_i})) begin
          state_d = ST_GATED;
          idle_d  = '0;
        end else if (!(&idle_q)) begin
          idle_d = idle_inc[CNT_W-1:0];
        end
      end
      ST_GATED: begin
        if (req_i) begin
          state_d = ST_WAKE;
          wake_d  = WK_W'(WAKE_CYC - 1);
        end
      end
      ST_WAKE: begin
        if (wake_q == '0) begin
          state_d = ST_ACTIVE;
          idle_d  = '0;
        end else begin
          wake_d = wake_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
        idle_d  = '0;
        wake_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
    end
  end

  assign ack_o   = (state_q == ST_ACTIVE);
  assign gated_o = (state_q == ST_GATED) & ~test_en_i;

  // Reset forces the enable so downstream logic sees clocks while it is reset.
  assign en = test_en_i | rst_i | (state_q != ST_GATED);

  always_latch begin
    if (!clk_i) en_lat = en;
  end

  assign clk_o = clk_i & en_lat;
endmodule

module ntt_intt_pwm_clkgate_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_en_i,
  input  logic [CNT_W-1:0]  cfg_idle_i,
  input  logic [NUM_CH-1:0] busy_i,
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] gated_o,
  output logic              all_gated_o,
  output logic [NUM_CH-1:0] clk_o
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ntt_intt_pwm_clkgate_ch #(
      .CNT_W    (CNT_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .test_en_i  (test_en_i),
      .cfg_idle_i (cfg_idle_i),
      .busy_i     (busy_i[g]),
      .req_i      (req_i[g]),
      .ack_o      (ack_o[g]),
      .gated_o    (gated_o[g]),
      .clk_o      (clk_o[g])
    );
  end

  assign all_gated_o = &gated_o;
endmodule

// File: tb/tb_ntt_intt_pwm_clkgate_ctrl.sv
// Directed bench for the clock gating controller: NUM_CH=2, WAKE_CYC=2, CNT_W=8.
`timescale 1ns/1ps
module tb_ntt_intt_pwm_clkgate_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       test_en_i;
  logic [7:0] cfg_idle_i;
  logic [1:0] busy_i, req_i, ack_o, gated_o, clk_o;
  logic       all_gated_o;

  int n_cmp = 0;
  int n_err = 0;
  int runt  = 0;
  int bad   = 0;
  time rise0 = 0, rise1 = 0;

  ntt_intt_pwm_clkgate_ctrl #(.NUM_CH(2), .CNT_W(8), .WAKE_CYC(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .test_en_i   (test_en_i),
    .cfg_idle_i  (cfg_idle_i),
    .busy_i      (busy_i),
    .req_i       (req_i),
    .ack_o       (ack_o),
    .gated_o     (gated_o),
    .all_gated_o (all_gated_o),
    .clk_o       (clk_o)
  );

  always #5 clk_i = ~clk_i;

  // Any gated high pulse narrower than the 5ns source high phase is a runt.
  always @(posedge clk_o[0]) rise0 = $time;
  always @(negedge clk_o[0]) if ($time - rise0 < 5) runt++;
  always @(posedge clk_o[1]) rise1 = $time;
  always @(negedge clk_o[1]) if ($time - rise1 < 5) runt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; test_en_i = 1'b0; cfg_idle_i = 8'd4; busy_i = 2'b00; req_i = 2'b00;
    repeat (3) step();
    chk("rst_ack", ack_o, 2'b11);
    chk("rst_gated", gated_o, 2'b00);
    chk("rst_allg", all_gated_o, 1'b0);
    chk("rst_clk", clk_o, 2'b11);

    // Auto-gate after 4 idle edges
    rst_i = 1'b0;
    repeat (3) step();
    chk("idle3_gated", gated_o, 2'b00);
    step();
    chk("idle4_gated", gated_o, 2'b11);
    chk("idle4_allg", all_gated_o, 1'b1);
    chk("idle4_ack", ack_o, 2'b00);
    chk("last_pulse", clk_o, 2'b11);
    step();
    chk("clk_stopped", clk_o, 2'b00);

    // Wake channel 0; req dropped mid-wake must not abort
    req_i = 2'b01;
    step();
    req_i = 2'b00;
    chk("w0_ack", ack_o, 2'b00);
    chk("w0_gated", gated_o, 2'b10);
    chk("w0_clk", clk_o, 2'b00);
    step();
    chk("w1_ack", ack_o, 2'b00);
    chk("w1_clk", clk_o, 2'b01);
    step();
    chk("w2_ack", ack_o, 2'b01);
    chk("w2_gated", gated_o, 2'b10);

    // Busy pulse after 3 idle cycles restarts the count
    repeat (3) step();
    chk("pre_busy", gated_o, 2'b10);
    busy_i = 2'b01;
    step();
    busy_i = 2'b00;
    repeat (3) step();
    chk("busy_cleared", gated_o, 2'b10);
    step();
    chk("regate", gated_o, 2'b11);

    // Lowering the threshold mid-count gates at the next idle edge
    req_i = 2'b01;
    step();
    req_i = 2'b00;
    repeat (2) step();
    chk("wake2_ack", ack_o, 2'b01);
    cfg_idle_i = 8'd8;
    repeat (3) step();
    chk("cfg8_cnt3", gated_o, 2'b10);
    cfg_idle_i = 8'd2;
    step();
    chk("cfg_lower", gated_o, 2'b11);
    cfg_idle_i = 8'd4;

    // Test override forces clocks without changing state
    test_en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("te_clk", clk_o, 2'b11);
      chk("te_gated", gated_o, 2'b00);
      chk("te_ack", ack_o, 2'b00);
    end
    test_en_i = 1'b0;
    step();
    chk("te_off_clk", clk_o, 2'b00);
    chk("te_off_gated", gated_o, 2'b11);
    step();
    chk("te_nowake", ack_o, 2'b00);

    // Reset while ch0 in WAKE and ch1 GATED
    req_i = 2'b01;
    step();
    req_i = 2'b00;
    chk("pre_rst_ack", ack_o, 2'b00);
    chk("pre_rst_gated", gated_o, 2'b10);
    rst_i = 1'b1;
    step();
    chk("mid_rst_ack", ack_o, 2'b11);
    chk("mid_rst_gated", gated_o, 2'b00);
    rst_i = 1'b0;
    cfg_idle_i = 8'd0;
    step();
    chk("post_rst_clk", clk_o, 2'b11);

    // Threshold 0 never gates
    for (int i = 0; i < 1000; i++) begin
      step();
      if (gated_o !== 2'b00 || clk_o !== 2'b11) bad++;
    end
    chk("cfg0_bad", bad, 0);

    // Held request keeps channels active; release gates after 4 idle edges
    cfg_idle_i = 8'd4;
    req_i = 2'b11;
    repeat (20) step();
    chk("hold_gated", gated_o, 2'b00);
    chk("hold_ack", ack_o, 2'b11);
    req_i = 2'b00;
    repeat (3) step();
    chk("rel3_gated", gated_o, 2'b00);
    step();
    chk("rel4_gated", gated_o, 2'b11);
    repeat (2) step();
    chk("runt", runt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
